// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature velocity path: FSM states,
// moving-average constants and the delta saturation function.
package quad_pkg;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } quad_state_t;

   localparam int AVG_TAPS  = 4;
   localparam int AVG_SHIFT = 2;

   // Clip a 32-bit signed delta into the signed range of a vel_w-bit word.
   function automatic logic signed [31:0] sat_clip(input logic signed [31:0] raw,
                                                   input int vel_w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (vel_w - 1)) - 1;
      lo = -(longint'(1) <<< (vel_w - 1));
      if (longint'(raw) > hi) begin
         return 32'(hi);
      end else if (longint'(raw) < lo) begin
         return 32'(lo);
      end
      return raw;
   endfunction

endpackage

// File: rtl/quad_tick_gen.sv
// Free-running sample-window timer: pulses tick on the last cycle of every
// SAMPLE_DIV-cycle window; synchronous reset restarts the window at 0.
module quad_tick_gen #(
   parameter int SAMPLE_DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int TW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   assign tick = (timer_q == TW'(SAMPLE_DIV - 1));

   always_comb begin
      timer_d = tick ? '0 : timer_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/quad_velocity.sv
// Velocity estimator: saturated position delta per sample window with a
// one-cycle valid strobe. Define QUAD_VEL_AVG_EN for a 4-tap moving average.
module quad_velocity
   import quad_pkg::*;
#(
   parameter int SAMPLE_DIV = 50000,
   parameter int VEL_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [31:0]      count,
   output logic signed [VEL_W-1:0] velocity,
   output logic                    vel_valid,
   output logic                    vel_sat
);

   logic                    tick;
   quad_state_t             state_q, state_d;
   logic signed [31:0]      prev_q;
   logic signed [31:0]      raw;
   logic signed [31:0]      clip;
   logic signed [VEL_W-1:0] dsat;
   logic                    dsat_flag;
   logic signed [VEL_W-1:0] vel_q, vel_d;
   logic                    sat_q, sat_d;
   logic                    valid_q;

   quad_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Modular subtraction absorbs position wrap-around.
   always_comb begin
      raw       = count - prev_q;
      clip      = sat_clip(raw, VEL_W);
      dsat      = clip[VEL_W-1:0];
      dsat_flag = (clip != raw);
   end

`ifdef QUAD_VEL_AVG_EN
   logic signed [VEL_W-1:0] hist_q [AVG_TAPS-1];
   logic [AVG_TAPS-2:0]     hsat_q;
   logic [1:0]              fill_q, fill_d;
   logic signed [VEL_W+1:0] sum;

   always_comb begin
      sum = (VEL_W+2)'(dsat);
      for (int i = 0; i < AVG_TAPS - 1; i++) begin
         sum = sum + (VEL_W+2)'(hist_q[i]);
      end
      vel_d = VEL_W'(sum >>> AVG_SHIFT);
      sat_d = dsat_flag | (|hsat_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < AVG_TAPS - 1; i++) hist_q[i] <= '0;
         hsat_q <= '0;
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
         if (tick && (state_q != ST_PRIME)) begin
            for (int i = AVG_TAPS - 2; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= dsat;
            hsat_q    <= {hsat_q[AVG_TAPS-3:0], dsat_flag};
         end
      end
   end
`else
   always_comb begin
      vel_d = dsat;
      sat_d = dsat_flag;
   end
`endif

   always_comb begin
      state_d = state_q;
`ifdef QUAD_VEL_AVG_EN
      fill_d  = fill_q;
`endif
      case (state_q)
         ST_PRIME: begin
            if (tick) begin
`ifdef QUAD_VEL_AVG_EN
               state_d = ST_FILL;
`else
               state_d = ST_RUN;
`endif
            end
         end
`ifdef QUAD_VEL_AVG_EN
         ST_FILL: begin
            if (tick) begin
               fill_d = fill_q + 2'd1;
               if (fill_q == 2'(AVG_TAPS - 2)) state_d = ST_RUN;
            end
         end
`endif
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_PRIME;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_PRIME;
         prev_q  <= '0;
         vel_q   <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= tick && (state_q == ST_RUN);
         if (tick) prev_q <= count;
         if (tick && (state_q == ST_RUN)) begin
            vel_q <= vel_d;
            sat_q <= sat_d;
         end
      end
   end

   assign velocity  = vel_q;
   assign vel_valid = valid_q;
   assign vel_sat   = sat_q;

endmodule
